// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and round-robin helper for the BRAM port arbiter
package bram_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef logic [1:0] req_idx_t;

    function automatic req_idx_t rr_next(input req_idx_t idx, input int n);
        return (int'(idx) >= n - 1) ? req_idx_t'(0) : idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first eligible requester at or after ptr
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] eligible,
    input  req_idx_t     ptr,
    output logic [N-1:0] grant,
    output logic         grant_any,
    output req_idx_t     grant_idx,
    output req_idx_t     next_ptr
);

    always_comb begin
        int j;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        next_ptr  = ptr;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!grant_any && eligible[j]) begin
                grant[j]  = 1'b1;
                grant_any = 1'b1;
                grant_idx = req_idx_t'(j);
                next_ptr  = rr_next(req_idx_t'(j), N);
            end
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// rtl/bram_rr_arbiter.sv - round-robin sharing of one single-port BRAM between NUM_REQ requesters
module bram_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           bram_write_en,
    output logic                           bram_read_en,
    output logic [ADDR_WIDTH-1:0]          bram_addr,
    output logic [DATA_WIDTH-1:0]          bram_write_data,
    input  logic [DATA_WIDTH-1:0]          bram_read_data,
    input  logic                           bram_valid
);

    req_idx_t               ptr;
    req_idx_t               next_ptr;
    req_idx_t               grant_idx;
    req_idx_t               read_tag;
    logic                   read_busy;
    logic                   grant_any;
    logic                   rsp_fire;
    logic                   read_ok;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     tag_onehot;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    // Releasing the response frees the read slot in the same cycle.
    assign rsp_fire   = |(rsp_valid & rsp_ready);
    assign read_ok    = !read_busy || rsp_fire;
    assign eligible   = req_valid & (req_we | {NUM_REQ{read_ok}});
    assign tag_onehot = NUM_REQ'(1) << read_tag;
    assign req_ready  = grant;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .eligible  (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_idx (grant_idx),
        .next_ptr  (next_ptr)
    );

    always_comb begin
        sel_we    = req_we[grant_idx];
        sel_addr  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr             <= '0;
            bram_write_en   <= 1'b0;
            bram_read_en    <= 1'b0;
            bram_addr       <= '0;
            bram_write_data <= '0;
        end else begin
            bram_write_en <= grant_any && sel_we;
            bram_read_en  <= grant_any && !sel_we;
            if (grant_any) begin
                ptr             <= next_ptr;
                bram_addr       <= sel_addr;
                bram_write_data <= sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_busy <= 1'b0;
            read_tag  <= '0;
        end else if (grant_any && !sel_we) begin
            read_busy <= 1'b1;
            read_tag  <= grant_idx;
        end else if (rsp_fire) begin
            read_busy <= 1'b0;
        end
    end

    // A stray bram_valid with no read outstanding never reaches a requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (rsp_fire) begin
            rsp_valid <= '0;
        end else if (bram_valid && read_busy && (rsp_valid == '0)) begin
            rsp_valid <= tag_onehot;
            rsp_data  <= bram_read_data;
        end
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_enables_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(bram_write_en && bram_read_en));
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (|(rsp_valid & ~rsp_ready)) |=> $stable(rsp_data));
    a_valid_expected: assert property (@(posedge clk) disable iff (!rst_n)
        bram_valid |-> read_busy);

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb/tb_bram_rr_arbiter.sv - directed-vector bench for bram_rr_arbiter with NUM_REQ=2 and NUM_REQ=3
module tb_bram_rr_arbiter;

    logic clk;
    logic rst_n;

    logic [1:0]  a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
    logic [19:0] a_req_addr;
    logic [31:0] a_req_wdata;
    logic [15:0] a_rsp_data, a_bram_wdata, a_bram_rdata;
    logic [9:0]  a_bram_addr;
    logic        a_bram_we, a_bram_re, a_bram_valid;

    logic [2:0]  b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [29:0] b_req_addr;
    logic [47:0] b_req_wdata;
    logic [15:0] b_rsp_data, b_bram_wdata, b_bram_rdata;
    logic [9:0]  b_bram_addr;
    logic        b_bram_we, b_bram_re, b_bram_valid;

    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bram_rr_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .NUM_REQ(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .bram_write_en(a_bram_we), .bram_read_en(a_bram_re), .bram_addr(a_bram_addr),
        .bram_write_data(a_bram_wdata), .bram_read_data(a_bram_rdata), .bram_valid(a_bram_valid)
    );

    bram_rr_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .NUM_REQ(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .bram_write_en(b_bram_we), .bram_read_en(b_bram_re), .bram_addr(b_bram_addr),
        .bram_write_data(b_bram_wdata), .bram_read_data(b_bram_rdata), .bram_valid(b_bram_valid)
    );

    // BRAM wrapper models: one-cycle read latency, valid is read_en delayed one cycle.
    always_ff @(posedge clk) begin
        if (a_bram_we) mem_a[a_bram_addr] <= a_bram_wdata;
        if (b_bram_we) mem_b[b_bram_addr] <= b_bram_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_bram_valid <= 1'b0;
            a_bram_rdata <= '0;
            b_bram_valid <= 1'b0;
            b_bram_rdata <= '0;
        end else begin
            a_bram_valid <= a_bram_re;
            b_bram_valid <= b_bram_re;
            if (a_bram_re) a_bram_rdata <= mem_a[a_bram_addr];
            if (b_bram_re) b_bram_rdata <= mem_b[b_bram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt0, cnt1, blocked, seen;
        logic [2:0] b_exp [4];
        b_exp[0] = 3'b001; b_exp[1] = 3'b010; b_exp[2] = 3'b100; b_exp[3] = 3'b001;

        rst_n = 1'b0;
        a_req_valid = '0; a_req_we = '0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = '0;
        b_req_valid = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 3'b111;
        tick; tick;
        chk("reset_req_ready", 32'(a_req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(a_rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(a_rsp_data), 32'h0);
        chk("reset_bram_en", {30'h0, a_bram_we, a_bram_re}, 32'h0);
        chk("reset_bram_addr", 32'(a_bram_addr), 32'h0);
        chk("reset_bram_wdata", 32'(a_bram_wdata), 32'h0);
        rst_n = 1'b1;
        tick;

        // req0 writes 0xBEEF to 0x005, req1 reads it back
        a_req_valid = 2'b01; a_req_we = 2'b01;
        a_req_addr[9:0] = 10'h005; a_req_wdata[15:0] = 16'hBEEF;
        #1 chk("wr_ready", 32'(a_req_ready), 32'h1);
        tick;
        a_req_valid = '0;
        chk("wr_bram_en", {30'h0, a_bram_we, a_bram_re}, 32'h2);
        chk("wr_bram_addr", 32'(a_bram_addr), 32'h005);
        chk("wr_bram_wdata", 32'(a_bram_wdata), 32'hBEEF);
        a_req_valid = 2'b10; a_req_we = 2'b00; a_req_addr[19:10] = 10'h005;
        #1 chk("rd_ready", 32'(a_req_ready), 32'h2);
        tick;
        a_req_valid = '0;
        chk("rd_bram_en", {30'h0, a_bram_we, a_bram_re}, 32'h1);
        chk("rd_bram_addr", 32'(a_bram_addr), 32'h005);
        tick;
        chk("rd_rsp_not_yet", 32'(a_rsp_valid), 32'h0);
        tick;
        chk("rd_rsp_valid", 32'(a_rsp_valid), 32'h2);
        chk("rd_rsp_data", 32'(a_rsp_data), 32'hBEEF);
        tick;
        chk("rd_rsp_held", 32'(a_rsp_valid), 32'h2);
        chk("rd_rsp_data_held", 32'(a_rsp_data), 32'hBEEF);
        a_rsp_ready = 2'b10;
        tick;
        chk("rd_rsp_released", 32'(a_rsp_valid), 32'h0);

        // Fairness: both writing continuously
        a_req_valid = 2'b11; a_req_we = 2'b11;
        a_req_addr = {10'h011, 10'h010}; a_req_wdata = {16'h1111, 16'h0000};
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (a_req_ready == 2'b01) cnt0++;
            if (a_req_ready == 2'b10) cnt1++;
            chk($sformatf("fair_grant%0d", i), 32'(a_req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick;
        end
        a_req_valid = '0;
        chk("fair_cnt0", 32'(cnt0), 32'd4);
        chk("fair_cnt1", 32'(cnt1), 32'd4);

        // Read-busy: req0 read held unacknowledged, req1 reads blocked, req1 write passes
        a_rsp_ready = 2'b00;
        a_req_valid = 2'b01; a_req_we = 2'b00; a_req_addr[9:0] = 10'h005;
        #1 chk("busy_rd0_ready", 32'(a_req_ready), 32'h1);
        tick;
        a_req_valid = 2'b10; a_req_addr[19:10] = 10'h020; a_req_wdata[31:16] = 16'h1234;
        blocked = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (a_req_ready != 2'b00) blocked++;
            tick;
        end
        chk("busy_rd1_blocked", 32'(blocked), 32'd0);
        chk("busy_rsp_valid", 32'(a_rsp_valid), 32'h1);
        chk("busy_rsp_data", 32'(a_rsp_data), 32'hBEEF);
        a_req_we = 2'b10;
        #1 chk("busy_wr1_ready", 32'(a_req_ready), 32'h2);
        tick;
        a_req_we = 2'b00;
        #1 chk("busy_rd1_still", 32'(a_req_ready), 32'h0);
        a_rsp_ready = 2'b01;
        #1 chk("busy_release_grant", 32'(a_req_ready), 32'h2);
        tick;
        a_req_valid = '0;
        chk("busy_rsp_cleared", 32'(a_rsp_valid), 32'h0);
        chk("busy_rd1_bram", {22'h0, a_bram_re, a_bram_addr}, {22'h0, 1'b1, 10'h020});
        tick; tick;
        chk("busy_rd1_rsp", 32'(a_rsp_valid), 32'h2);
        chk("busy_rd1_data", 32'(a_rsp_data), 32'h1234);
        a_rsp_ready = 2'b11;
        tick;
        chk("busy_rd1_done", 32'(a_rsp_valid), 32'h0);

        // NUM_REQ=3: pointer wraps 2->0, top address write/read
        b_req_valid = 3'b111; b_req_we = 3'b111;
        b_req_addr = {10'h102, 10'h101, 10'h100};
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("n3_grant%0d", i), 32'(b_req_ready), 32'(b_exp[i]));
            tick;
        end
        b_req_valid = 3'b100; b_req_we = 3'b100;
        b_req_addr[29:20] = 10'h3FF; b_req_wdata[47:32] = 16'hA5A5;
        #1 chk("n3_wr2_ready", 32'(b_req_ready), 32'h4);
        tick;
        chk("n3_wr_bram", {6'h0, b_bram_we, b_bram_re, b_bram_addr, b_bram_wdata},
            {6'h0, 1'b1, 1'b0, 10'h3FF, 16'hA5A5});
        b_req_valid = 3'b001; b_req_we = 3'b000; b_req_addr[9:0] = 10'h3FF;
        #1 chk("n3_wrap_rd0_ready", 32'(b_req_ready), 32'h1);
        tick;
        b_req_valid = '0;
        chk("n3_rd_bram", {20'h0, b_bram_re, 1'b0, b_bram_addr}, {20'h0, 1'b1, 1'b0, 10'h3FF});
        tick; tick;
        chk("n3_rsp_valid", 32'(b_rsp_valid), 32'h1);
        chk("n3_rsp_data", 32'(b_rsp_data), 32'hA5A5);
        tick;
        chk("n3_rsp_done", 32'(b_rsp_valid), 32'h0);

        // Reset between read issue and bram_valid drops the read
        a_req_valid = 2'b01; a_req_we = 2'b00; a_req_addr[9:0] = 10'h005;
        #1;
        tick;
        a_req_valid = '0;
        chk("rst_pre_bram_re", 32'(a_bram_re), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bram", {a_bram_we, a_bram_re, a_bram_addr, 4'h0, a_bram_wdata}, 32'h0);
        chk("rst_mid_rsp", {14'h0, a_rsp_valid, a_rsp_data}, 32'h0);
        chk("rst_mid_ready", 32'(a_req_ready), 32'h0);
        tick; tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (a_rsp_valid != 2'b00) seen++;
        end
        chk("rst_no_rsp_after", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
